// File: rtl/palindrome_detector.sv
// Sliding-window serial palindrome detector with registered flag, fill tracking and window view.
// Optional saturating match counter: define PALINDROME_MATCH_CNT_EN to build it.
module palindrome_detector #(
   parameter int LEN   = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             valid_i,
   input  logic             x_i,
   output logic             palindrome_o,
   output logic [LEN-1:0]   window_o,
   output logic             full_o,
   output logic [CNT_W-1:0] match_cnt_o
);
   localparam int                FILL_W   = $clog2(LEN + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN);

   function automatic logic f_is_sym(input logic [LEN-1:0] w);
      logic sym;
      sym = 1'b1;
      for (int i = 0; i < LEN / 2; i++) begin
         sym = sym & (w[i] == w[LEN-1-i]);
      end
      return sym;
   endfunction

   logic [LEN-1:0]    r_window;
   logic [FILL_W-1:0] r_fill;
   logic              r_full;
   logic              r_pal;

   logic [LEN-1:0]    w_window_nxt;
   logic [FILL_W-1:0] w_fill_nxt;
   logic              w_full_nxt;
   logic              w_pal_nxt;

   // Post-shift window, saturating fill and the evaluation it feeds.
   always_comb begin
      w_window_nxt = {r_window[LEN-2:0], x_i};
      if (r_fill == FILL_MAX) begin
         w_fill_nxt = r_fill;
      end else begin
         w_fill_nxt = r_fill + FILL_W'(1);
      end
      w_full_nxt = (w_fill_nxt == FILL_MAX);
      w_pal_nxt  = w_full_nxt & f_is_sym(w_window_nxt);
   end

   // Window, fill and flag state; clear outranks an accepted bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_window <= {LEN{1'b0}};
         r_fill   <= {FILL_W{1'b0}};
         r_full   <= 1'b0;
         r_pal    <= 1'b0;
      end else if (clear_i) begin
         r_window <= {LEN{1'b0}};
         r_fill   <= {FILL_W{1'b0}};
         r_full   <= 1'b0;
         r_pal    <= 1'b0;
      end else if (valid_i) begin
         r_window <= w_window_nxt;
         r_fill   <= w_fill_nxt;
         r_full   <= w_full_nxt;
         r_pal    <= w_pal_nxt;
      end
   end

   assign palindrome_o = r_pal;
   assign window_o     = r_window;
   assign full_o       = r_full;

`ifdef PALINDROME_MATCH_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Counts accepting edges that raise the flag; holds at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (clear_i) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (valid_i && w_pal_nxt && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign match_cnt_o = r_cnt;
`else
   assign match_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_palindrome_detector.sv
// Directed bench for palindrome_detector: four instances (LEN 5, 4, 3, 2) driven step by step.
module tb_palindrome_detector;
`ifdef PALINDROME_MATCH_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic        clk;
   logic        rst_n;
   logic        vld [4];
   logic        xb  [4];
   logic        clr [4];
   logic        pal [4];
   logic        full[4];
   logic [4:0]  win5;
   logic [3:0]  win4;
   logic [2:0]  win3;
   logic [1:0]  win2;
   logic [15:0] cnt5, cnt4, cnt3;
   logic [1:0]  cnt2;

   int checks = 0;
   int errors = 0;

   palindrome_detector #(.LEN(5), .CNT_W(16)) u5 (
      .clk(clk), .reset(rst_n), .clear_i(clr[0]), .valid_i(vld[0]), .x_i(xb[0]),
      .palindrome_o(pal[0]), .window_o(win5), .full_o(full[0]), .match_cnt_o(cnt5));
   palindrome_detector #(.LEN(4), .CNT_W(16)) u4 (
      .clk(clk), .reset(rst_n), .clear_i(clr[1]), .valid_i(vld[1]), .x_i(xb[1]),
      .palindrome_o(pal[1]), .window_o(win4), .full_o(full[1]), .match_cnt_o(cnt4));
   palindrome_detector #(.LEN(3), .CNT_W(16)) u3 (
      .clk(clk), .reset(rst_n), .clear_i(clr[2]), .valid_i(vld[2]), .x_i(xb[2]),
      .palindrome_o(pal[2]), .window_o(win3), .full_o(full[2]), .match_cnt_o(cnt3));
   palindrome_detector #(.LEN(2), .CNT_W(2)) u2 (
      .clk(clk), .reset(rst_n), .clear_i(clr[3]), .valid_i(vld[3]), .x_i(xb[3]),
      .palindrome_o(pal[3]), .window_o(win2), .full_o(full[3]), .match_cnt_o(cnt2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_cnt(input int n);
      return (CNT_ON != 0) ? 32'(n) : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock step on instance k; outputs are sampled 1 time unit after the edge.
   task automatic step(input int k, input logic v, input logic b, input logic c);
      @(negedge clk);
      vld[k] = v;
      xb[k]  = b;
      clr[k] = c;
      @(posedge clk);
      #1;
      vld[k] = 1'b0;
      xb[k]  = 1'b0;
      clr[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         vld[k] = 1'b0; xb[k] = 1'b0; clr[k] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pal", pal[0], 32'd0);
      chk("rst_full", full[0], 32'd0);
      chk("rst_win", win5, 32'd0);
      chk("rst_cnt", cnt5, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // LEN=5: 1,0,1,0 stays unflagged, fifth bit 1 completes 10101
      step(0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0);
      step(0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0);
      chk("a_pal4", pal[0], 32'd0);
      chk("a_full4", full[0], 32'd0);
      chk("a_win4", win5, 32'h0A);
      step(0, 1'b1, 1'b1, 1'b0);
      chk("a_pal5", pal[0], 32'd1);
      chk("a_full5", full[0], 32'd1);
      chk("a_win5", win5, 32'h15);
      chk("a_cnt5", cnt5, exp_cnt(1));
      step(0, 1'b0, 1'b0, 1'b0);
      chk("hold_pal", pal[0], 32'd1);
      chk("hold_win", win5, 32'h15);
      chk("hold_cnt", cnt5, exp_cnt(1));

      // overlap: 0 then 1 give two more palindromes
      step(0, 1'b1, 1'b0, 1'b0);
      chk("b_pal6", pal[0], 32'd1);
      chk("b_win6", win5, 32'h0A);
      step(0, 1'b1, 1'b1, 1'b0);
      chk("b_pal7", pal[0], 32'd1);
      chk("b_cnt7", cnt5, exp_cnt(3));

      // clear beats valid, x=1 discarded
      step(0, 1'b1, 1'b1, 1'b1);
      chk("c_pal", pal[0], 32'd0);
      chk("c_full", full[0], 32'd0);
      chk("c_win", win5, 32'd0);
      chk("c_cnt", cnt5, 32'd0);

      // symmetric but partial window must not flag
      for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0);
      chk("d_pal_part", pal[0], 32'd0);
      chk("d_full_part", full[0], 32'd0);
      step(0, 1'b1, 1'b0, 1'b0);
      chk("d_pal_full", pal[0], 32'd1);
      chk("d_full", full[0], 32'd1);
      chk("d_cnt", cnt5, exp_cnt(1));
      step(0, 1'b1, 1'b1, 1'b0);
      chk("d_pal_no", pal[0], 32'd0);
      chk("d_win", win5, 32'h01);
      chk("d_cnt_hold", cnt5, exp_cnt(1));

      // LEN=4: 1,0, gap of 3, 0,1 -> flagged once after bit 4
      step(1, 1'b1, 1'b1, 1'b0);
      step(1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1, 1'b0, 1'b1, 1'b0);
      chk("e_gap_win", win4, 32'h2);
      chk("e_gap_pal", pal[1], 32'd0);
      step(1, 1'b1, 1'b0, 1'b0);
      chk("e_pal3", pal[1], 32'd0);
      chk("e_full3", full[1], 32'd0);
      step(1, 1'b1, 1'b1, 1'b0);
      chk("e_pal4", pal[1], 32'd1);
      chk("e_win4", win4, 32'h9);
      chk("e_cnt4", cnt4, exp_cnt(1));
      step(1, 1'b1, 1'b1, 1'b0);
      chk("e_pal5", pal[1], 32'd0);

      // LEN=2, CNT_W=2: six ones, counter saturates at 3
      step(3, 1'b1, 1'b1, 1'b0);
      chk("f_pal1", pal[3], 32'd0);
      chk("f_full1", full[3], 32'd0);
      for (int i = 2; i <= 6; i++) begin
         step(3, 1'b1, 1'b1, 1'b0);
         chk("f_pal", pal[3], 32'd1);
         chk("f_cnt", cnt2, exp_cnt((i - 1) > 3 ? 3 : (i - 1)));
      end

      // LEN=3: two bits, async reset mid-cycle, then 0,1,0
      step(2, 1'b1, 1'b1, 1'b0);
      step(2, 1'b1, 1'b1, 1'b0);
      chk("g_win_pre", win3, 32'h3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("g_async_win", win3, 32'd0);
      chk("g_async_full", full[2], 32'd0);
      chk("g_async_pal", pal[2], 32'd0);
      chk("g_async_cnt2", cnt2, 32'd0);
      rst_n = 1'b1;
      step(2, 1'b1, 1'b0, 1'b0);
      chk("g_full1", full[2], 32'd0);
      chk("g_win1", win3, 32'd0);
      step(2, 1'b1, 1'b1, 1'b0);
      chk("g_full2", full[2], 32'd0);
      chk("g_pal2", pal[2], 32'd0);
      step(2, 1'b1, 1'b0, 1'b0);
      chk("g_pal3", pal[2], 32'd1);
      chk("g_full3", full[2], 32'd1);
      chk("g_win3", win3, 32'h2);
      chk("g_cnt3", cnt3, exp_cnt(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/palindrome_detector.md
PALINDROME_DETECTOR -- requirements
Module: palindrome_detector

Interface
REQ-001 SHALL provide parameter LEN, default 5, meaning detection window length in bits; legal range 2..32.
REQ-002 SHALL provide parameter CNT_W, default 16, meaning width of the match counter.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port clear_i  input  1  synchronous clear of window, fill state and counter.
REQ-006 SHALL provide port valid_i  input  1  qualifies x_i; bit accepted only when high.
REQ-007 SHALL provide port x_i  input  1  serial data bit.
REQ-008 SHALL provide port palindrome_o  output  1  registered flag: current full window is a palindrome.
REQ-009 SHALL provide port window_o  output  LEN  current window; bit 0 is the newest accepted bit.
REQ-010 SHALL provide port full_o  output  1  high once LEN bits have been accepted since reset or clear.
REQ-011 SHALL provide port match_cnt_o  output  CNT_W  number of detections (see Configuration).

Function
REQ-012 SHALL, on each cycle with valid_i=1 and clear_i=0, shift x_i into window bit 0 and move every older bit up one position.
REQ-013 SHALL hold window, fill count, palindrome_o and counter unchanged on cycles with valid_i=0.
REQ-014 SHALL use a fill counter of width ceil(log2(LEN+1)) that increments per accepted bit and saturates at LEN; full_o = (fill == LEN), registered.
REQ-015 SHALL evaluate the palindrome condition on the post-shift window: bit i equals bit LEN-1-i for all i < LEN/2; the middle bit is ignored for odd LEN.
REQ-016 SHALL assert palindrome_o in the cycle after the accepting edge (1-cycle latency) only if the post-shift window is full and palindromic; otherwise deassert it on that accepting edge.
REQ-017 SHALL detect overlapping windows: every accepted bit after full produces a fresh evaluation, so consecutive palindromes yield consecutive assertions.
REQ-018 SHALL keep palindrome_o at 0 while fill < LEN, even if the partially filled window is symmetric.
REQ-019 SHALL give clear_i priority over valid_i: on clear, window, fill, full_o, palindrome_o and counter go to 0 and x_i on that cycle is discarded.
REQ-020 SHALL increment the match counter on each accepting edge that sets palindrome_o, saturating at 2^CNT_W-1 with no wrap.

Reset
REQ-021 SHALL, on reset low, immediately drive palindrome_o=0, full_o=0, window_o=0, match_cnt_o=0 and fill count=0, independent of clk.
REQ-022 SHALL resume accepting bits on the first rising clk edge after reset deasserts; a reset mid-stream discards all partial window content.

Configuration
REQ-023 SHALL use macro PALINDROME_MATCH_CNT_EN: when defined, the saturating match counter of REQ-020 is implemented; when undefined, no counter flops exist and match_cnt_o is tied to 0.
REQ-024 SHALL keep all other behaviour identical with or without PALINDROME_MATCH_CNT_EN.

Verification
REQ-025 LEN=5: after reset, valid bits 1,0,1,0 -> palindrome_o stays 0 and full_o=0; fifth bit 1 -> full_o=1 and palindrome_o=1 one cycle later, window_o=5'b10101.
REQ-026 LEN=5, stream 1,0,1,0,1,0,1 fully valid -> palindrome_o high for three consecutive evaluations (overlap); match_cnt_o=3 with macro defined, 0 without.
REQ-027 LEN=4, stream 1,0,0,1 with valid_i low for 3 cycles between bits 2 and 3 -> palindrome_o=1 exactly once, after bit 4; no change during gaps.
REQ-028 LEN=5, window full and palindrome_o=1, assert clear_i with valid_i=1,x_i=1 -> next cycle palindrome_o=0, full_o=0, window_o=0, match_cnt_o=0.
REQ-029 LEN=3, reset pulsed low mid-cycle after 2 bits -> outputs 0 asynchronously; next 3 bits 0,1,0 -> palindrome_o=1, proving no residue from before reset.
REQ-030 CNT_W=2, macro defined, LEN=2, stream of 6 ones -> match_cnt_o saturates at 3 and holds; palindrome_o stays 1.
